fft_sdf_stage: RTL and testbench
================================

# fft_sdf_stage

Parametrised radix-2 decimation-in-frequency FFT stage in single-path delay-feedback (SDF) form. It streams one complex sample per valid cycle. Instances are cascaded with STAGE = 0 … LOG2N-1 to build an N-point pipelined FFT, replacing the fixed 8-point parallel stage blocks. The block has the following internals:
- a feedback FIFO of depth D = 2^(LOG2N-1-STAGE)
- butterfly add/subtract
- twiddle multiply with rounding and saturation
- frame-phase tracking with sync error detection

## Interface
- W, 16: data width of each real/imag component, two's complement
- LOG2N, 3: log2 of FFT size N
- STAGE, 1: stage index, 0 … LOG2N-1
- SCALE, 0: 1 = halve every butterfly result; 0 = saturate without scaling

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample present
- in_sop  in  1  first sample of a frame (qualified by in_valid)
- flush  in  1  advance the pipeline with zero input when in_valid=0
- in_re, in_im  in  W  input sample
- tw_idx  out  LOG2N-1  twiddle index, combinational from state
- tw_re, tw_im  in  W  twiddle from an external asynchronous ROM, Q2.(W-2) format (1.0 = 2^(W-2))
- out_valid  out  1  output sample present
- out_sop  out  1  first output of a frame
- out_re, out_im  out  W  output sample
- ovf  out  1  sticky flag, set on any saturation
- sync_err  out  1  sticky flag, set on a misaligned in_sop

## Operation
- Advance cycle: in_valid=1, or flush=1 with in_valid=0 (input treated as 0+0j, in_sop ignored). in_valid has priority over flush. Without an advance, all state holds and out_valid=0 on the next cycle.
- cnt: LOG2N-bit counter that increments on every advance and wraps at N-1 to 0.
  - h = cnt bit (LOG2N-1-STAGE)
  - k = cnt low bits below h
  - tw_idx = k << STAGE (for STAGE = LOG2N-1, tw_idx = 0)
- h=0 (fill/drain half). Let f be the FIFO head.
  - Output f × twiddle(tw_idx).
  - Push the input into the FIFO.
- h=1 (butterfly half). Let a be the FIFO head and b the input.
  - Output a+b.
  - Push a-b into the FIFO.
- Butterfly arithmetic:
  - Computed at W+1 bits.
  - SCALE=1: result = (x+1)>>>1, which always fits in W bits.
  - SCALE=0: result saturates to [-2^(W-1), 2^(W-1)-1].
- Complex multiply:
  - re = fr·tr - fi·ti and im = fr·ti + fi·tr, computed at 2W+1 bits.
  - Round: (p + 2^(W-3)) >>> (W-2).
  - Saturate to W bits.
  - tw = 1.0 is exact, so the data passes unchanged.
- ovf sets on any saturation event in a cycle whose output is valid.
- Priming: after reset or resync, the first D advances produce no valid output (the FIFO holds no real data yet). All later advances produce one output each.
- Frame sync: when in_valid=1 and in_sop=1:
  - cnt≠0: force cnt to 0 for this sample, set sync_err, re-enter the unprimed state. FIFO contents are discarded logically and not zeroed.
  - cnt=0: no action.
- out_sop=1 on the output produced by the advance at cnt=D, when the frame began with an aligned in_sop.

## Timing
- Reset values: out_valid=0, out_sop=0, out_re=0, out_im=0, ovf=0, sync_err=0, cnt=0, FIFO=0, unprimed.
- Outputs are registered. The result of an advance appears on the next clk edge, with out_valid=1 for exactly one cycle per primed advance.
- Latency: output stream = input stream delayed by D advances plus 1 clk. Output order is the standard DIF stage order.
- tw_idx changes only after advances. tw_re and tw_im are sampled combinationally in the same cycle.
- Reset asserted mid-frame clears all state immediately, with no output of partial data.
- Gaps in in_valid stretch the timing without corrupting data. The last D differences of a stream drain via flush or via the next frame.

## Test plan
Unless noted: W=16, LOG2N=3, STAGE=1, SCALE=0, so D=2. Twiddle ROM: idx0 = (16384, 0), idx1 = (11585, -11585), idx2 = (0, -16384), idx3 = (-11585, -11585).

- Basic butterfly and twiddle: inputs 1, 2, 3, 4 (imag 0) with sop on the first, then 2 flush cycles.
  - Outputs: (4,0) with out_sop, (6,0), (-2,0), (0,2).
  - out_valid is first high 1 clk after the 3rd advance.
- Saturation: SCALE=0, inputs 32767, 0, 32767, 0 → first output 32767, ovf=1. Repeat with SCALE=1 → 32767, ovf=0.
- Gapped input: the basic stimulus with in_valid low for 3 cycles between every sample → identical output values and count. out_valid never asserts during the gaps.
- Misaligned sop: in_sop asserted at cnt=1 → sync_err=1 and stays set. The next 2 advances produce no out_valid. The following frame output matches the aligned case.
- Reset mid-frame: rst low after 5 advances → all outputs 0 at once. After release, the basic stimulus reproduces the basic-case results exactly.
- Last stage: STAGE=2 (D=1), inputs 5, 3 → outputs (8,0) with out_sop, then (2,0) after flush. tw_idx stays 0 throughout.

Source files
------------

// File: rtl/fft_sdf_stage.sv
// fft_sdf_stage: one radix-2 decimation-in-frequency stage in single-path
// delay-feedback form. One complex sample enters per advance; cascading
// STAGE = 0..LOG2N-1 builds an N-point pipelined FFT.
module fft_sdf_stage #(
  parameter int W     = 16,
  parameter int LOG2N = 3,
  parameter int STAGE = 1,
  parameter int SCALE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic                flush,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic [LOG2N-2:0]    tw_idx,
  input  logic signed [W-1:0] tw_re,
  input  logic signed [W-1:0] tw_im,
  output logic                out_valid,
  output logic                out_sop,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic                ovf,
  output logic                sync_err
);
  localparam int HB = LOG2N-1-STAGE;   // counter bit selecting the butterfly half
  localparam int D  = 1 << HB;         // feedback FIFO depth
  localparam int PW = 2*W+1;           // working width for all arithmetic
  localparam logic [LOG2N-1:0]     D_CNT   = LOG2N'(D);
  localparam logic [LOG2N-1:0]     DM1_CNT = LOG2N'(D-1);
  localparam logic [LOG2N-2:0]     KMASK   = (LOG2N-1)'((1 << HB) - 1);
  localparam logic signed [PW-1:0] ONE     = PW'(1);
  localparam logic signed [PW-1:0] RND     = PW'(1 << (W-3));
  localparam logic signed [PW-1:0] SMAX    = PW'((1 << (W-1)) - 1);
  localparam logic signed [PW-1:0] SMIN    = -SMAX - ONE;

  // Clamp to W bits; MSB of the result flags that clamping happened.
  function automatic logic [W:0] sat_w(input logic signed [PW-1:0] x);
    logic [W:0] r;
    if (x > SMAX)      r = {1'b1, SMAX[W-1:0]};
    else if (x < SMIN) r = {1'b1, SMIN[W-1:0]};
    else               r = {1'b0, x[W-1:0]};
    return r;
  endfunction

  // Butterfly post-processing: halving with round-half-up always fits, so
  // the clamp only ever fires in the unscaled mode.
  function automatic logic [W:0] bfly(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] t;
    t = (SCALE != 0) ? ((x + ONE) >>> 1) : x;
    return sat_w(t);
  endfunction

  logic [LOG2N-1:0]      cnt_q, cnt_e;
  logic                  primed_q, primed_e, sop_ok_q;
  logic [D-1:0][W-1:0]   fre_q, fim_q;
  logic                  out_valid_q, out_sop_q, ovf_q, serr_q;
  logic signed [W-1:0]   out_re_q, out_im_q;
  logic                  adv, resync, h;
  logic signed [W-1:0]   a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]  p_re, p_im;
  logic [W:0]            s_re, s_im, d_re, d_im, m_re, m_im;
  logic signed [W-1:0]   out_re_d, out_im_d, push_re_d, push_im_d;
  logic                  sat_d;

  // A misaligned sop restarts the frame on this very sample.
  assign adv      = in_valid | flush;
  assign resync   = in_valid & in_sop & (cnt_q != '0);
  assign cnt_e    = resync ? '0 : cnt_q;
  assign primed_e = primed_q & ~resync;
  assign h        = cnt_e[HB];
  assign tw_idx   = (cnt_q[LOG2N-2:0] & KMASK) << STAGE;

  assign a_re = fre_q[D-1];
  assign a_im = fim_q[D-1];
  assign b_re = in_valid ? in_re : '0;
  assign b_im = in_valid ? in_im : '0;

  assign s_re = bfly(PW'(a_re) + PW'(b_re));
  assign s_im = bfly(PW'(a_im) + PW'(b_im));
  assign d_re = bfly(PW'(a_re) - PW'(b_re));
  assign d_im = bfly(PW'(a_im) - PW'(b_im));

  assign p_re = PW'(a_re) * PW'(tw_re) - PW'(a_im) * PW'(tw_im);
  assign p_im = PW'(a_re) * PW'(tw_im) + PW'(a_im) * PW'(tw_re);
  assign m_re = sat_w((p_re + RND) >>> (W-2));
  assign m_im = sat_w((p_im + RND) >>> (W-2));

  // Fill/drain half emits the rotated FIFO head and stores the input;
  // butterfly half emits a+b and recirculates a-b.
  always_comb begin
    out_re_d  = m_re[W-1:0];
    out_im_d  = m_im[W-1:0];
    push_re_d = b_re;
    push_im_d = b_im;
    sat_d     = m_re[W] | m_im[W];
    if (h) begin
      out_re_d  = s_re[W-1:0];
      out_im_d  = s_im[W-1:0];
      push_re_d = d_re[W-1:0];
      push_im_d = d_im[W-1:0];
      sat_d     = s_re[W] | s_im[W] | d_re[W] | d_im[W];
    end
  end

  // Frame phase, FIFO shift, registered outputs and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      sop_ok_q    <= 1'b0;
      fre_q       <= '0;
      fim_q       <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      ovf_q       <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      out_valid_q <= adv & primed_e;
      out_sop_q   <= adv & primed_e & sop_ok_q & (cnt_e == D_CNT);
      if (adv) begin
        cnt_q    <= cnt_e + LOG2N'(1);
        primed_q <= primed_e | (cnt_e == DM1_CNT);
        if (cnt_e == '0) sop_ok_q <= in_valid & in_sop & ~resync;
        for (int i = 1; i < D; i++) begin
          fre_q[i] <= fre_q[i-1];
          fim_q[i] <= fim_q[i-1];
        end
        fre_q[0] <= push_re_d;
        fim_q[0] <= push_im_d;
        if (primed_e) begin
          out_re_q <= out_re_d;
          out_im_q <= out_im_d;
          ovf_q    <= ovf_q | sat_d;
        end
        if (resync) serr_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign ovf       = ovf_q;
  assign sync_err  = serr_q;
endmodule

// File: tb/tb_fft_sdf_stage.sv
// Scoreboard bench for fft_sdf_stage: three instances (STAGE=1 SCALE=0,
// STAGE=1 SCALE=1, STAGE=2) with hand-computed expected output streams.
module tb_fft_sdf_stage;
  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        sop;
    logic        care;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [2:0]       vld, sop, fl;
  logic [2:0][15:0] ire, iim, twr, twm, ore, oim;
  logic [2:0][1:0]  twi;
  logic [2:0]       ov, osop, oovf, oserr;
  exp_t             q0[$], q1[$], q2[$];
  int               n_chk = 0;
  int               n_fail = 0;

  fft_sdf_stage #(.W(16), .LOG2N(3), .STAGE(1), .SCALE(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_sop(sop[0]), .flush(fl[0]),
    .in_re(ire[0]), .in_im(iim[0]), .tw_idx(twi[0]), .tw_re(twr[0]), .tw_im(twm[0]),
    .out_valid(ov[0]), .out_sop(osop[0]), .out_re(ore[0]), .out_im(oim[0]),
    .ovf(oovf[0]), .sync_err(oserr[0]));

  fft_sdf_stage #(.W(16), .LOG2N(3), .STAGE(1), .SCALE(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_sop(sop[1]), .flush(fl[1]),
    .in_re(ire[1]), .in_im(iim[1]), .tw_idx(twi[1]), .tw_re(twr[1]), .tw_im(twm[1]),
    .out_valid(ov[1]), .out_sop(osop[1]), .out_re(ore[1]), .out_im(oim[1]),
    .ovf(oovf[1]), .sync_err(oserr[1]));

  fft_sdf_stage #(.W(16), .LOG2N(3), .STAGE(2), .SCALE(0)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_sop(sop[2]), .flush(fl[2]),
    .in_re(ire[2]), .in_im(iim[2]), .tw_idx(twi[2]), .tw_re(twr[2]), .tw_im(twm[2]),
    .out_valid(ov[2]), .out_sop(osop[2]), .out_re(ore[2]), .out_im(oim[2]),
    .ovf(oovf[2]), .sync_err(oserr[2]));

  // Twiddle ROM for N=8, Q2.14
  function automatic logic [31:0] rom(input logic [1:0] i);
    logic [31:0] r;
    case (i)
      2'd0:    r = {16'(16384),  16'(0)};
      2'd1:    r = {16'(11585),  16'(-11585)};
      2'd2:    r = {16'(0),      16'(-16384)};
      default: r = {16'(-11585), 16'(-11585)};
    endcase
    return r;
  endfunction

  assign {twr[0], twm[0]} = rom(twi[0]);
  assign {twr[1], twm[1]} = rom(twi[1]);
  assign {twr[2], twm[2]} = rom(twi[2]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_out(input string nm, input exp_t e, input logic s,
                         input logic [15:0] r, input logic [15:0] i);
    chk({nm, " re"}, int'(r), int'(e.re));
    chk({nm, " im"}, int'(i), int'(e.im));
    if (e.care) chk({nm, " out_sop"}, int'(s), int'(e.sop));
  endtask

  task automatic ex(input int d, input int re, input int im, input logic s, input logic c);
    exp_t e;
    e.re = 16'(re); e.im = 16'(im); e.sop = s; e.care = c;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Expected stream of the 1,2,3,4 frame (4 samples + 4 flushes) on a STAGE=1 instance
  task automatic ex_frame(input int d, input bit primed, input logic c);
    if (primed) begin ex(d, 0, 0, 1'b0, 1'b1); ex(d, 0, 0, 1'b0, 1'b1); end
    ex(d,  4, 0, 1'b1, c);
    ex(d,  6, 0, 1'b0, c);
    ex(d, -2, 0, 1'b0, c);
    ex(d,  0, 2, 1'b0, c);
    ex(d,  0, 0, 1'b0, c);
    ex(d,  0, 0, 1'b0, c);
  endtask

  // One cycle of stimulus; returns #1 after the edge that samples it
  task automatic step(input int d, input logic v, input logic s, input logic f, input int re);
    vld[d] = v; sop[d] = s; fl[d] = f; ire[d] = 16'(re); iim[d] = 16'(0);
    @(posedge clk); #1;
    vld[d] = 1'b0; sop[d] = 1'b0; fl[d] = 1'b0; ire[d] = '0; iim[d] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic adv(input int d, input logic v, input logic s, input logic f,
                     input int re, input int gap);
    step(d, v, s, f, re);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      chk("no out_valid in gap", int'(ov[d]), 0);
    end
  endtask

  task automatic run_frame(input int d, input int x0, input int x1, input int x2,
                           input int x3, input int gap);
    adv(d, 1'b1, 1'b1, 1'b0, x0, gap);
    adv(d, 1'b1, 1'b0, 1'b0, x1, gap);
    adv(d, 1'b1, 1'b0, 1'b0, x2, gap);
    adv(d, 1'b1, 1'b0, 1'b0, x3, gap);
    repeat (4) adv(d, 1'b0, 1'b0, 1'b1, 0, gap);
  endtask

  // Monitors: every presented output must match the head of its queue
  always @(negedge clk) begin
    if (ov[0] === 1'b1) begin
      if (q0.size() == 0) chk("dut0 spurious out_valid", q0.size(), 1);
      else cmp_out("dut0", q0.pop_front(), osop[0], ore[0], oim[0]);
    end
    if (ov[1] === 1'b1) begin
      if (q1.size() == 0) chk("dut1 spurious out_valid", q1.size(), 1);
      else cmp_out("dut1", q1.pop_front(), osop[1], ore[1], oim[1]);
    end
    if (ov[2] === 1'b1) begin
      if (q2.size() == 0) chk("dut2 spurious out_valid", q2.size(), 1);
      else cmp_out("dut2", q2.pop_front(), osop[2], ore[2], oim[2]);
    end
  end

  initial begin
    vld = '0; sop = '0; fl = '0; ire = '0; iim = '0;
    rst = 1'b0;
    idle(2);
    for (int d = 0; d < 3; d++) begin
      chk("reset out_valid", int'(ov[d]), 0);
      chk("reset out_sop", int'(osop[d]), 0);
      chk("reset out_re", int'(ore[d]), 0);
      chk("reset out_im", int'(oim[d]), 0);
      chk("reset ovf", int'(oovf[d]), 0);
      chk("reset sync_err", int'(oserr[d]), 0);
    end
    rst = 1'b1;
    idle(1);

    // basic butterfly + twiddle, with latency and tw_idx probes
    ex_frame(0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b0, 1); chk("basic no valid adv1", int'(ov[0]), 0);
    step(0, 1'b1, 1'b0, 1'b0, 2); chk("basic no valid adv2", int'(ov[0]), 0);
    step(0, 1'b1, 1'b0, 1'b0, 3); chk("basic valid adv3", int'(ov[0]), 1);
    step(0, 1'b1, 1'b0, 1'b0, 4);
    step(0, 1'b0, 1'b0, 1'b1, 0); chk("basic tw_idx at cnt5", int'(twi[0]), 2);
    repeat (3) step(0, 1'b0, 1'b0, 1'b1, 0);
    idle(2);
    chk("basic ovf", int'(oovf[0]), 0);
    chk("basic sync_err", int'(oserr[0]), 0);

    // gapped input: same values, nothing valid in the gaps
    ex_frame(0, 1'b1, 1'b1);
    run_frame(0, 1, 2, 3, 4, 3);
    idle(2);

    // saturation, unscaled
    ex(0, 0, 0, 1'b0, 1'b1); ex(0, 0, 0, 1'b0, 1'b1);
    ex(0, 32767, 0, 1'b1, 1'b1);
    repeat (5) ex(0, 0, 0, 1'b0, 1'b1);
    run_frame(0, 32767, 0, 32767, 0, 0);
    idle(2);
    chk("sat SCALE=0 ovf", int'(oovf[0]), 1);

    // saturation case with halving
    ex(1, 32767, 0, 1'b1, 1'b1);
    repeat (5) ex(1, 0, 0, 1'b0, 1'b1);
    run_frame(1, 32767, 0, 32767, 0, 0);
    idle(2);
    chk("sat SCALE=1 ovf", int'(oovf[1]), 0);

    // misaligned sop at cnt=1
    ex(0, 0, 0, 1'b0, 1'b1);
    ex_frame(0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 9);
    step(0, 1'b1, 1'b1, 1'b0, 1);
    chk("resync sync_err", int'(oserr[0]), 1);
    chk("resync adv no valid", int'(ov[0]), 0);
    step(0, 1'b1, 1'b0, 1'b0, 2);
    chk("resync next adv no valid", int'(ov[0]), 0);
    step(0, 1'b1, 1'b0, 1'b0, 3);
    step(0, 1'b1, 1'b0, 1'b0, 4);
    repeat (4) step(0, 1'b0, 1'b0, 1'b1, 0);
    idle(2);
    chk("sync_err sticky", int'(oserr[0]), 1);
    ex_frame(0, 1'b1, 1'b1);
    run_frame(0, 1, 2, 3, 4, 0);
    idle(2);

    // reset mid-frame
    ex(0, 0, 0, 1'b0, 1'b1); ex(0, 0, 0, 1'b0, 1'b1);
    ex(0, 4, 0, 1'b1, 1'b1); ex(0, 6, 0, 1'b0, 1'b1); ex(0, -2, 0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b0, 1);
    step(0, 1'b1, 1'b0, 1'b0, 2);
    step(0, 1'b1, 1'b0, 1'b0, 3);
    step(0, 1'b1, 1'b0, 1'b0, 4);
    step(0, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midreset out_valid", int'(ov[0]), 0);
    chk("midreset out_sop", int'(osop[0]), 0);
    chk("midreset out_re", int'(ore[0]), 0);
    chk("midreset out_im", int'(oim[0]), 0);
    chk("midreset ovf", int'(oovf[0]), 0);
    chk("midreset sync_err", int'(oserr[0]), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    ex_frame(0, 1'b0, 1'b1);
    run_frame(0, 1, 2, 3, 4, 0);
    idle(2);

    // last stage, D=1
    ex(2, 8, 0, 1'b1, 1'b1);
    ex(2, 2, 0, 1'b0, 1'b1);
    step(2, 1'b1, 1'b1, 1'b0, 5); chk("last tw_idx a", int'(twi[2]), 0);
    step(2, 1'b1, 1'b0, 1'b0, 3); chk("last tw_idx b", int'(twi[2]), 0);
    step(2, 1'b0, 1'b0, 1'b1, 0); chk("last tw_idx c", int'(twi[2]), 0);
    idle(3);

    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);
    chk("dut2 queue drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
